link_reset_pattern_gen: RTL and testbench

Output stage of the ETROC2 readout channel, sitting directly downstream of the global readout path. It takes the 32-bit scrambled word and passes it on to the 1280 MHz serializer. On a link-reset request from either the fast-command or the slow-control path, it replaces the data for a programmable number of 40 MHz cycles with a PRBS7 or user-fixed alignment pattern, sized to the active serializer rate. Everything runs in the 40 MHz domain.

---
 rtl/link_reset_pattern_gen.sv | 143 ++++++++++++++
 tb/tb_link_reset_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_reset_pattern_gen.sv
// ETROC2 readout output stage: passes scrambled data to the serializer, or emits a
// PRBS7 / fixed alignment pattern for HOLD_CYCLES words after a link-reset request.
module link_reset_pattern_gen #(
  parameter int unsigned HOLD_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dis,
  input  logic [1:0]  serRate,
  input  logic [31:0] din,
  input  logic        linkResetFast,
  input  logic        linkResetSlow,
  input  logic        testPatternSel,
  input  logic [31:0] fixedTestPattern,
  output logic [31:0] dout,
  output logic        linkResetActive
);

  localparam logic [15:0] HOLD = 16'(HOLD_CYCLES);

  typedef enum logic {NORMAL, PATTERN} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  prbs_q, prbs_d;
  logic [31:0] dout_q, dout_d;
  logic        sync1_q, sync2_q, sync3_q, edge_q;
  logic [1:0]  settle_q;

  logic        trig;
  logic [31:0] mask;
  logic [31:0] prbs_bits;
  logic [6:0]  s, s8, s16, s32;
  logic        b;

  // The sync chain restarts from zero after dis; settle_q masks the false
  // 0->1 edge that a level already high at release would otherwise produce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      edge_q   <= 1'b0;
      settle_q <= 2'd0;
    end else if (dis) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      edge_q   <= 1'b0;
      settle_q <= 2'd3;
    end else begin
      sync1_q  <= linkResetSlow;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      edge_q   <= (settle_q == 2'd0) & sync2_q & ~sync3_q;
      if (settle_q != 2'd0) settle_q <= settle_q - 2'd1;
    end
  end

  assign trig = linkResetFast | edge_q;

  always_comb begin
    case (serRate)
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
  end

  // Unrolled PRBS7: 32 bits from the current state, tapping the state after 8/16/32 steps.
  always_comb begin
    s         = prbs_q;
    b         = 1'b0;
    prbs_bits = '0;
    s8        = prbs_q;
    s16       = prbs_q;
    for (int i = 0; i < 32; i++) begin
      b            = s[6] ^ s[5];
      prbs_bits[i] = b;
      s            = {s[5:0], b};
      if (i == 7)  s8  = s;
      if (i == 15) s16 = s;
    end
    s32 = s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prbs_d  = prbs_q;
    dout_d  = din & mask;
    if (dis) begin
      state_d = NORMAL;
      cnt_d   = '0;
      dout_d  = '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (trig) begin
            state_d = PATTERN;
            cnt_d   = HOLD;
            prbs_d  = 7'h7F;
          end
        end
        PATTERN: begin
          dout_d = (testPatternSel ? fixedTestPattern : prbs_bits) & mask;
          case (serRate)
            2'b00:   prbs_d = s8;
            2'b01:   prbs_d = s16;
            default: prbs_d = s32;
          endcase
          if (trig) begin
            cnt_d = HOLD;
          end else if (cnt_q == 16'd1) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      prbs_q  <= 7'h7F;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prbs_q  <= prbs_d;
      dout_q  <= dout_d;
    end
  end

  assign dout            = dout_q;
  assign linkResetActive = (state_q == PATTERN);

endmodule

// File: tb/tb_link_reset_pattern_gen.sv
// Directed bench for link_reset_pattern_gen with a reference PRBS7 model.
module tb_link_reset_pattern_gen;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        reset, dis, linkResetFast, linkResetSlow, testPatternSel;
  logic [1:0]  serRate;
  logic [31:0] din, fixedTestPattern, dout;
  logic        linkResetActive;

  int          checks = 0, errors = 0;
  logic [6:0]  ms;

  link_reset_pattern_gen #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .dis(dis), .serRate(serRate), .din(din),
    .linkResetFast(linkResetFast), .linkResetSlow(linkResetSlow),
    .testPatternSel(testPatternSel), .fixedTestPattern(fixedTestPattern),
    .dout(dout), .linkResetActive(linkResetActive)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wmask(input logic [1:0] r);
    return (r == 2'b00) ? 32'h0000_00FF : (r == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic gen_word(input logic [1:0] r, output logic [31:0] w);
    int   n;
    logic bb;
    n = (r == 2'b00) ? 8 : (r == 2'b01) ? 16 : 32;
    w = '0;
    for (int i = 0; i < n; i++) begin
      bb   = ms[6] ^ ms[5];
      w[i] = bb;
      ms   = {ms[5:0], bb};
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = $urandom; fixedTestPattern = $urandom; serRate = 2'($urandom_range(0, 3));
      linkResetFast = 1'($urandom_range(0, 1)); linkResetSlow = 1'($urandom_range(0, 1));
      testPatternSel = 1'($urandom_range(0, 1));
      tick;
      checks++;
      if (dout !== 32'h0 || linkResetActive !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: dout=%h active=%b expected dout=0 active=0", dout, linkResetActive);
      end
    end
    linkResetFast = 0; linkResetSlow = 0; dis = 0; testPatternSel = 0;
    serRate = 2'b10; din = 32'hDEADBEEF;
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (dout !== 32'hDEADBEEF || linkResetActive !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: dout=%h active=%b expected dout=deadbeef active=0", dout, linkResetActive);
    end
  endtask

  task automatic test_prbs(input logic [1:0] rate, input logic [31:0] first_exp);
    logic [31:0] exp;
    serRate = rate; testPatternSel = 0; din = 32'hA5C3_1234;
    tick;
    linkResetFast = 1; tick; linkResetFast = 0;
    checks++;
    if (linkResetActive !== 1'b1 || dout !== (din & wmask(rate))) begin
      errors++;
      $display("FAIL prbs%0d_start: dout=%h active=%b expected dout=%h active=1", rate, dout, linkResetActive, din & wmask(rate));
    end
    ms = 7'h7F;
    for (int i = 0; i < H; i++) begin
      din = din + 32'h0101_0101;
      tick;
      gen_word(rate, exp);
      checks++;
      if (dout !== exp || linkResetActive !== 1'(i < H - 1)) begin
        errors++;
        $display("FAIL prbs%0d_word%0d: dout=%h active=%b expected dout=%h active=%b", rate, i, dout, linkResetActive, exp, i < H - 1);
      end
      if (i == 0) begin
        checks++;
        if (dout !== first_exp) begin
          errors++;
          $display("FAIL prbs%0d_first: dout=%h expected %h", rate, dout, first_exp);
        end
      end
    end
    din = 32'h1357_9BDF;
    tick;
    checks++;
    if (dout !== (din & wmask(rate)) || linkResetActive !== 1'b0) begin
      errors++;
      $display("FAIL prbs%0d_resume: dout=%h active=%b expected dout=%h active=0", rate, dout, linkResetActive, din & wmask(rate));
    end
  endtask

  task automatic test_fixed;
    serRate = 2'b01; testPatternSel = 1; fixedTestPattern = 32'h3C5C_ABCD; din = 32'h7777_5555;
    tick;
    linkResetFast = 1; tick; linkResetFast = 0;
    for (int i = 0; i < H; i++) begin
      tick;
      checks++;
      if (dout !== 32'h0000_ABCD) begin
        errors++;
        $display("FAIL fixed_word%0d: dout=%h expected 0000abcd", i, dout);
      end
    end
    tick;
    checks++;
    if (dout !== 32'h0000_5555 || linkResetActive !== 1'b0) begin
      errors++;
      $display("FAIL fixed_resume: dout=%h active=%b expected dout=00005555 active=0", dout, linkResetActive);
    end
    testPatternSel = 0;
  endtask

  task automatic test_slow_retrigger;
    logic [31:0] exp;
    logic        seen;
    serRate = 2'b10; testPatternSel = 0; din = 32'h0F0F_F0F0;
    tick;
    linkResetSlow = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (linkResetActive !== 1'b0) begin
        errors++;
        $display("FAIL slow_latency%0d: active=%b expected 0", i, linkResetActive);
      end
    end
    tick;
    checks++;
    if (linkResetActive !== 1'b1 || dout !== 32'h0F0F_F0F0) begin
      errors++;
      $display("FAIL slow_start: dout=%h active=%b expected dout=0f0ff0f0 active=1", dout, linkResetActive);
    end
    ms = 7'h7F;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) linkResetFast = 1;
      tick;
      linkResetFast = 0;
      gen_word(2'b10, exp);
      checks++;
      if (dout !== exp || linkResetActive !== 1'(i < 11)) begin
        errors++;
        $display("FAIL retrig_word%0d: dout=%h active=%b expected dout=%h active=%b", i, dout, linkResetActive, exp, i < 11);
      end
    end
    seen = 0;
    for (int i = 0; i < 980; i++) begin
      tick;
      if (linkResetActive) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL slow_level_rerequest: active seen=%b expected 0", seen);
    end
    linkResetSlow = 0;
    tick; tick; tick; tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    serRate = 2'b00; testPatternSel = 0; din = 32'h0000_0011;
    tick;
    linkResetFast = 1; tick; linkResetFast = 0;
    ms = 7'h7F;
    for (int i = 0; i < 2 * H; i++) begin
      if (i == H - 1) linkResetFast = 1;
      tick;
      linkResetFast = 0;
      gen_word(2'b00, exp);
      checks++;
      if (dout !== exp || linkResetActive !== 1'(i < 2 * H - 1)) begin
        errors++;
        $display("FAIL b2b_word%0d: dout=%h active=%b expected dout=%h active=%b", i, dout, linkResetActive, exp, i < 2 * H - 1);
      end
    end
    tick;
  endtask

  task automatic test_disable;
    logic bad;
    serRate = 2'b01; din = 32'h1234_5678;
    tick;
    linkResetFast = 1; tick; linkResetFast = 0;
    tick; tick; tick;
    dis = 1; linkResetSlow = 1;
    tick;
    checks++;
    if (dout !== 32'h0 || linkResetActive !== 1'b0) begin
      errors++;
      $display("FAIL dis_mid_burst: dout=%h active=%b expected dout=0 active=0", dout, linkResetActive);
    end
    linkResetFast = 1;
    tick; tick;
    linkResetFast = 0;
    checks++;
    if (dout !== 32'h0 || linkResetActive !== 1'b0) begin
      errors++;
      $display("FAIL dis_hold: dout=%h active=%b expected dout=0 active=0", dout, linkResetActive);
    end
    dis = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (linkResetActive !== 1'b0 || dout !== 32'h0000_5678) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL dis_release_no_burst: dout=%h active=%b expected dout=00005678 active=0", dout, linkResetActive);
    end
    linkResetSlow = 0;
    tick; tick;
  endtask

  task automatic test_reset_midburst;
    serRate = 2'b10; din = 32'hCAFE_0001;
    tick;
    linkResetFast = 1; tick; linkResetFast = 0;
    tick; tick;
    #1 reset = 1;
    #1;
    checks++;
    if (dout !== 32'h0 || linkResetActive !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_abort: dout=%h active=%b expected dout=0 active=0", dout, linkResetActive);
    end
    tick;
    reset = 0;
    tick;
    checks++;
    if (dout !== 32'hCAFE_0001 || linkResetActive !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume: dout=%h active=%b expected dout=cafe0001 active=0", dout, linkResetActive);
    end
  endtask

  initial begin
    reset = 1; dis = 0; linkResetFast = 0; linkResetSlow = 0; testPatternSel = 0;
    serRate = 2'b00; din = '0; fixedTestPattern = '0;
    test_reset;
    test_prbs(2'b00, 32'h0000_0040);
    test_prbs(2'b01, 32'h0000_3040);
    test_fixed;
    test_slow_retrigger;
    test_back_to_back;
    test_disable;
    test_reset_midburst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
